// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO controller: address width and the
// almost-full threshold derived from it.
package fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 4;

  // Almost-full sits two entries below capacity unless overridden.
  function automatic int default_af_lvl(input int addr_width);
    return (2 ** addr_width) - 2;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: advances by one on inc and rolls over at 2**ADDR_WIDTH.
module fifo_ptr #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl_status.sv
// FIFO control and status: pointers, occupancy count, registered level flags
// and sticky overflow/underflow errors for an external storage array.
module fifo_ctrl_status
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AE_LVL     = 2,
  parameter int AF_LVL     = default_af_lvl(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic                  clr_err,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  we,
  output logic                  re,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_LVL);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_LVL);

  if (AE_LVL >= AF_LVL || AF_LVL > DEPTH) begin : g_bad_levels
    $error("fifo_ctrl_status: need AE_LVL < AF_LVL <= DEPTH");
  end

  logic [ADDR_WIDTH:0] count_next;
  logic                overflow_set;
  logic                underflow_set;

  // A simultaneous read frees a slot, so a write into a full FIFO still lands.
  assign we = reset & wr & (~full | rd);
  assign re = reset & rd & ~empty;

  assign overflow_set  = wr & ~rd & full;
  assign underflow_set = rd & ~wr & empty;

  always_comb begin
    count_next = count;
    case ({we, re})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (we),
    .ptr   (w_addr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (re),
    .ptr   (r_addr)
  );

  // Flags are decoded from the next count so they line up with count itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == DEPTH_CNT);
      almost_empty <= (count_next <= AE_CNT);
      almost_full  <= (count_next >= AF_CNT);
    end
  end

  // A new error wins over a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow_set  | (overflow  & ~clr_err);
      underflow <= underflow_set | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_status.sv
// Scoreboard bench for fifo_ctrl_status: a queue-based occupancy model predicts
// every output each cycle and a separate monitor compares them against the DUT.
module tb_fifo_ctrl_status;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AE    = 2;
  localparam int AF    = 14;

  logic          clk;
  logic          reset;
  logic          rd;
  logic          wr;
  logic          clr_err;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          we;
  logic          re;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic          overflow;
  logic          underflow;

  typedef struct {
    int we;
    int re;
    int count;
    int w_addr;
    int r_addr;
    int empty;
    int full;
    int almost_empty;
    int almost_full;
    int overflow;
    int underflow;
  } expect_t;

  expect_t sb[$];

  int occ[$];
  int wr_total;
  int rd_total;
  int ovf_model;
  int unf_model;
  int token;

  int tests;
  int failures;

  fifo_ctrl_status #(
    .ADDR_WIDTH (AW),
    .AE_LVL     (AE),
    .AF_LVL     (AF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rd           (rd),
    .wr           (wr),
    .clr_err      (clr_err),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .we           (we),
    .re           (re),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, predict what the DUT must
  // show until the next rising edge, then advance the model past that edge.
  task automatic applyStimulus(input logic rst, input logic r, input logic w, input logic c);
    expect_t e;
    int      sz;
    int      nxt_ovf;
    int      nxt_unf;
    @(negedge clk);
    reset   = rst;
    rd      = r;
    wr      = w;
    clr_err = c;
    #1;
    if (!rst) begin
      occ.delete();
      wr_total  = 0;
      rd_total  = 0;
      ovf_model = 0;
      unf_model = 0;
    end
    sz             = occ.size();
    e.count        = sz;
    e.w_addr       = wr_total % DEPTH;
    e.r_addr       = rd_total % DEPTH;
    e.empty        = (sz == 0) ? 1 : 0;
    e.full         = (sz == DEPTH) ? 1 : 0;
    e.almost_empty = (sz <= AE) ? 1 : 0;
    e.almost_full  = (sz >= AF) ? 1 : 0;
    e.overflow     = ovf_model;
    e.underflow    = unf_model;
    e.we           = (rst && w && (sz < DEPTH || r)) ? 1 : 0;
    e.re           = (rst && r && sz > 0) ? 1 : 0;
    sb.push_back(e);
    if (rst) begin
      nxt_ovf = ((w && !r && sz == DEPTH) || (ovf_model != 0 && !c)) ? 1 : 0;
      nxt_unf = ((r && !w && sz == 0) || (unf_model != 0 && !c)) ? 1 : 0;
      if (e.re != 0) begin
        void'(occ.pop_front());
        rd_total++;
      end
      if (e.we != 0) begin
        occ.push_back(token);
        token++;
        wr_total++;
      end
      ovf_model = nxt_ovf;
      unf_model = nxt_unf;
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: DUT outputs are valid every cycle, so each pending prediction is
  // compared shortly after the falling edge, clear of the rising edge.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("we",           int'(we),           e.we);
        checkOutput("re",           int'(re),           e.re);
        checkOutput("count",        int'(count),        e.count);
        checkOutput("w_addr",       int'(w_addr),       e.w_addr);
        checkOutput("r_addr",       int'(r_addr),       e.r_addr);
        checkOutput("empty",        int'(empty),        e.empty);
        checkOutput("full",         int'(full),         e.full);
        checkOutput("almost_empty", int'(almost_empty), e.almost_empty);
        checkOutput("almost_full",  int'(almost_full),  e.almost_full);
        checkOutput("overflow",     int'(overflow),     e.overflow);
        checkOutput("underflow",    int'(underflow),    e.underflow);
      end
    end
  end

  initial begin
    int pw;
    int pr;
    int drain;
    tests     = 0;
    failures  = 0;
    token     = 0;
    wr_total  = 0;
    rd_total  = 0;
    ovf_model = 0;
    unf_model = 0;
    reset     = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    clr_err   = 1'b0;
    pw        = 50;
    pr        = 50;

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Fill to capacity, then push once more into a full FIFO.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);

    // Drain, read once while empty, then read+write while empty.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Error raised and cleared in the same cycle must stay set.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       begin pw = 80; pr = 25; end
          1:       begin pw = 25; pr = 80; end
          default: begin pw = 50; pr = 50; end
        endcase
      end
      applyStimulus(($urandom_range(0, 1999) != 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < pr) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < pw) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(negedge clk);
      #3;
      drain++;
    end
    if (sb.size() > 0) begin
      tests++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
